// File: rtl/onoff_input_buffer.sv
// Per-VC circular input FIFOs with on/off (hysteresis) flow control toward the upstream router.
// A flit arriving at a full VC is dropped and latches a sticky error flag.
module onoff_input_buffer #(
    parameter int unsigned VC_NUM        = 2,
    parameter int unsigned BUFFER_SIZE   = 8,
    parameter int unsigned FLIT_SIZE     = 32,
    parameter int unsigned OFF_THRESHOLD = 6,
    parameter int unsigned ON_THRESHOLD  = 3,
    localparam int unsigned VC_SIZE      = $clog2(VC_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [FLIT_SIZE-1:0]                data_i,
    input  logic                                valid_i,
    input  logic [VC_SIZE-1:0]                  vc_i,
    input  logic [VC_NUM-1:0]                   read_i,
    output logic [VC_NUM-1:0][FLIT_SIZE-1:0]    data_o,
    output logic [VC_NUM-1:0]                   switch_request_o,
    output logic [VC_NUM-1:0]                   on_off_o,
    output logic                                error_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [FLIT_SIZE-1:0]            mem [VC_NUM][BUFFER_SIZE];
    logic [VC_NUM-1:0][PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [VC_NUM-1:0][CNT_W-1:0]    count_q, count_d;
    logic [VC_NUM-1:0]               on_off_q, on_off_d;
    logic [VC_NUM-1:0]               push, pop, accept;
    logic                            error_q, drop;

    always_comb begin
        push     = '0;
        pop      = '0;
        accept   = '0;
        count_d  = count_q;
        on_off_d = on_off_q;
        drop     = 1'b0;
        if (valid_i) push[vc_i] = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            pop[v]     = read_i[v] && (count_q[v] != '0);
            // A same-cycle pop frees a slot, so a full VC can still accept.
            accept[v]  = push[v] && ((count_q[v] != CNT_W'(BUFFER_SIZE)) || pop[v]);
            drop       = drop | (push[v] & ~accept[v]);
            count_d[v] = count_q[v] + CNT_W'(accept[v]) - CNT_W'(pop[v]);
            if (count_d[v] >= CNT_W'(OFF_THRESHOLD)) begin
                on_off_d[v] = 1'b0;
            end else if (count_d[v] <= CNT_W'(ON_THRESHOLD)) begin
                on_off_d[v] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            on_off_q <= '1;
            error_q  <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (accept[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
                if (pop[v])    rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
            end
            count_q  <= count_d;
            on_off_q <= on_off_d;
            if (drop) error_q <= 1'b1;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (rst && accept[v]) mem[v][wr_ptr_q[v]] <= data_i;
        end
    end

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            data_o[v]           = mem[v][rd_ptr_q[v]];
            switch_request_o[v] = (count_q[v] != '0);
        end
        on_off_o = on_off_q;
        error_o  = error_q;
    end

endmodule
